// File: rtl/ghash_core_gf128_if.sv
// Block-level bus for ghash_core_gf128: load enable, operands and the
// registered GHASH accumulator. The master drives a block in, the slave
// (the core) returns Y.
interface ghash_core_gf128_if #(
    parameter int unsigned NB_DATA = 128
) ();
    logic               i_valid;
    logic [NB_DATA-1:0] i_data_x;
    logic [NB_DATA-1:0] i_data_x_prev;
    logic [NB_DATA-1:0] i_h_key;
    logic [NB_DATA-1:0] o_data_y;

    modport master (
        output i_valid,
        output i_data_x,
        output i_data_x_prev,
        output i_h_key,
        input  o_data_y
    );

    modport slave (
        input  i_valid,
        input  i_data_x,
        input  i_data_x_prev,
        input  i_h_key,
        output o_data_y
    );
endinterface

// File: rtl/ghash_core_gf128.sv
// Single-block GHASH step: Y = (X ^ Y_prev) * H in GF(2^128), GCM
// bit-reflected order (bit 127 is the x^0 coefficient), registered output.
// Optional macro GHASH_CORE_PIPE_EN splits the multiplier after iteration 63
// with one extra register stage (latency 2 instead of 1).
module ghash_core_gf128 #(
    parameter int unsigned NB_DATA = 128
) (
    input  logic              i_clock,
    input  logic              i_reset,
    ghash_core_gf128_if.slave bus
);
    localparam int unsigned HALF = NB_DATA / 2;
    // x^128 = x^7 + x^2 + x + 1, expressed in reflected order
    localparam logic [NB_DATA-1:0] RED = {8'hE1, {(NB_DATA - 8){1'b0}}};

    logic [NB_DATA-1:0] x_op;
    logic [NB_DATA-1:0] y_d, y_q;

    assign x_op         = bus.i_data_x ^ bus.i_data_x_prev;
    assign bus.o_data_y = y_q;

`ifdef GHASH_CORE_PIPE_EN
    logic [NB_DATA-1:0] z_mid_d, z_mid_q;
    logic [NB_DATA-1:0] v_mid_d, v_mid_q;
    logic [HALF-1:0]    x_lo_q;

    // Iterations 0..63: consume the upper half of X, MSB first
    always_comb begin
        logic [NB_DATA-1:0] xs;
        xs      = x_op;
        z_mid_d = '0;
        v_mid_d = bus.i_h_key;
        for (int i = 0; i < int'(HALF); i++) begin
            if (xs[NB_DATA-1]) z_mid_d = z_mid_d ^ v_mid_d;
            v_mid_d = v_mid_d[0] ? ((v_mid_d >> 1) ^ RED) : (v_mid_d >> 1);
            xs      = xs << 1;
        end
    end

    // Mid-multiplier stage: same reset/enable rules as the output register
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            z_mid_q <= '0;
            v_mid_q <= '0;
            x_lo_q  <= '0;
        end else if (bus.i_valid) begin
            z_mid_q <= z_mid_d;
            v_mid_q <= v_mid_d;
            x_lo_q  <= x_op[HALF-1:0];
        end
    end

    // Iterations 64..127: finish on the registered lower half of X
    always_comb begin
        logic [HALF-1:0]    xs;
        logic [NB_DATA-1:0] v;
        xs  = x_lo_q;
        v   = v_mid_q;
        y_d = z_mid_q;
        for (int i = 0; i < int'(HALF); i++) begin
            if (xs[HALF-1]) y_d = y_d ^ v;
            v  = v[0] ? ((v >> 1) ^ RED) : (v >> 1);
            xs = xs << 1;
        end
    end
`else
    // Fully unrolled shift-and-add multiply, X scanned MSB first
    always_comb begin
        logic [NB_DATA-1:0] xs;
        logic [NB_DATA-1:0] v;
        xs  = x_op;
        v   = bus.i_h_key;
        y_d = '0;
        for (int i = 0; i < int'(NB_DATA); i++) begin
            if (xs[NB_DATA-1]) y_d = y_d ^ v;
            v  = v[0] ? ((v >> 1) ^ RED) : (v >> 1);
            xs = xs << 1;
        end
    end
`endif

    // Output register: reset wins over load, holds when i_valid is low
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            y_q <= '0;
        end else if (bus.i_valid) begin
            y_q <= y_d;
        end
    end
endmodule

// File: tb/tb_ghash_core_gf128.sv
// Self-checking bench for ghash_core_gf128: one standalone instance for
// directed and random products, plus a 5-deep chain for GCM test case 15.
// Reference model: reflect operands, carry-less multiply, reduce, reflect back.
module tb_ghash_core_gf128;
`ifdef GHASH_CORE_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    localparam int NCH = 5;
    localparam logic [127:0] H_TC = 128'hacbef20579b4b8ebce889bac8732dad7;
    localparam logic [127:0] Y_TC = 128'h4db870d37cb75fcb46097c36230d1612;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    int           n_checks = 0;
    int           n_errors = 0;

    always #5 clk = ~clk;

    // Standalone instance
    ghash_core_gf128_if if_s ();
    ghash_core_gf128 u_single (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (if_s)
    );

    // Chained instances
    logic         ch_rst   = 1'b1;
    logic         ch_valid = 1'b0;
    logic [127:0] ch_key   = '0;
    logic [127:0] ch_x [NCH];
    logic [127:0] ch_y [NCH];
    ghash_core_gf128_if if_c [NCH] ();

    for (genvar g = 0; g < NCH; g++) begin : g_chain
        assign if_c[g].i_valid  = ch_valid;
        assign if_c[g].i_h_key  = ch_key;
        assign if_c[g].i_data_x = ch_x[g];
        assign ch_y[g]          = if_c[g].o_data_y;
        if (g == 0) begin : g_first
            assign if_c[g].i_data_x_prev = '0;
        end else begin : g_next
            assign if_c[g].i_data_x_prev = if_c[g-1].o_data_y;
        end
        ghash_core_gf128 u_dut (
            .i_clock (clk),
            .i_reset (ch_rst),
            .bus     (if_c[g])
        );
    end

    function automatic logic [127:0] reflect(input logic [127:0] a);
        logic [127:0] r;
        for (int i = 0; i < 128; i++) r[i] = a[127-i];
        return r;
    endfunction

    // Plain polynomial arithmetic: bit i of the reflected value is x^i
    function automatic logic [127:0] gf_mul_ref(input logic [127:0] a, input logic [127:0] b);
        logic [127:0] pa;
        logic [127:0] pb;
        logic [254:0] prod;
        logic [254:0] poly;
        pa   = reflect(a);
        pb   = reflect(b);
        prod = '0;
        poly = (255'h1 << 128) | 255'h87;
        for (int i = 0; i < 128; i++)
            if (pa[i]) prod = prod ^ ({127'b0, pb} << i);
        for (int d = 254; d >= 128; d--)
            if (prod[d]) prod = prod ^ (poly << (d - 128));
        return reflect(prod[127:0]);
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [127:0] x, input logic [127:0] p,
                         input logic [127:0] h);
        if_s.i_valid       = v;
        if_s.i_data_x      = x;
        if_s.i_data_x_prev = p;
        if_s.i_h_key       = h;
    endtask

    // Advance n rising edges and settle just after the last one
    task automatic step(input int n);
        for (int i = 0; i < n; i++) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [127:0] x, p, h, y_hold, y_exp;
        logic [127:0] tc_blk [NCH];

        tc_blk[0] = 128'h522dc1f099567d07f47f37a32a84427d;
        tc_blk[1] = 128'h643a8cdcbfe5c0c97598a2bd2555d1aa;
        tc_blk[2] = 128'h8cb08e48590dbb3da7b08b1056828838;
        tc_blk[3] = 128'hc5f61e6393ba7a0abcc9f662898015ad;
        tc_blk[4] = 128'h00000000000000000000000000000200;
        for (int i = 0; i < NCH; i++) ch_x[i] = '0;

        // Reset with arbitrary inputs and i_valid high
        drive(1'b1, rnd128(), rnd128(), rnd128());
        rst = 1'b1;
        step(1);
        check("reset_cycle1", if_s.o_data_y, '0);
        drive(1'b1, rnd128(), rnd128(), rnd128());
        step(1);
        check("reset_cycle2", if_s.o_data_y, '0);
        @(negedge clk);
        rst = 1'b0;

        // Identity: 0x80..0 is the field element 1
        drive(1'b1, 128'h8000_0000_0000_0000_0000_0000_0000_0000, '0, H_TC);
        step(LAT);
        check("identity", if_s.o_data_y, H_TC);

        // Zero operand via X == prev
        x = rnd128();
        drive(1'b1, x, x, rnd128());
        step(LAT);
        check("zero_x_eq_prev", if_s.o_data_y, '0);

        // Zero operand via H == 0
        drive(1'b1, rnd128(), rnd128(), '0);
        step(LAT);
        check("zero_h", if_s.o_data_y, '0);

        // Random products against the reference model
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            x = rnd128();
            p = (k % 4 == 0) ? '0 : rnd128();
            h = (k == 1) ? H_TC : rnd128();
            drive(1'b1, x, p, h);
            step(LAT);
            check($sformatf("rand_%0d", k), if_s.o_data_y, gf_mul_ref(x ^ p, h));
        end

        // Hold: drop i_valid, change every input, output must not move
        @(negedge clk);
        x = rnd128();
        h = rnd128();
        drive(1'b1, x, '0, h);
        step(LAT);
        y_hold = gf_mul_ref(x, h);
        check("hold_load", if_s.o_data_y, y_hold);
        @(negedge clk);
        drive(1'b0, rnd128(), rnd128(), rnd128());
        step(3);
        check("hold_idle", if_s.o_data_y, y_hold);
        @(negedge clk);
        x = rnd128();
        p = rnd128();
        h = rnd128();
        drive(1'b1, x, p, h);
        step(LAT);
        check("hold_resume", if_s.o_data_y, gf_mul_ref(x ^ p, h));

        // Reset has priority over i_valid
        @(negedge clk);
        rst = 1'b1;
        drive(1'b1, rnd128(), rnd128(), rnd128());
        step(1);
        check("reset_priority", if_s.o_data_y, '0);
        @(negedge clk);
        rst = 1'b0;

        // GCM test case 15 through the 5-deep chain
        @(negedge clk);
        ch_key   = H_TC;
        ch_valid = 1'b1;
        for (int i = 0; i < NCH; i++) ch_x[i] = tc_blk[i];
        step(1);
        @(negedge clk);
        ch_rst = 1'b0;
        step(NCH * LAT);
        y_exp = '0;
        for (int i = 0; i < NCH; i++) begin
            y_exp = gf_mul_ref(tc_blk[i] ^ y_exp, H_TC);
            check($sformatf("chain_y%0d", i), ch_y[i], y_exp);
        end
        check("chain_final", ch_y[NCH-1], Y_TC);

        // Reset mid-chain: all stages clear on the next edge, then re-settle
        @(negedge clk);
        ch_rst = 1'b1;
        step(1);
        for (int i = 0; i < NCH; i++) check($sformatf("chain_rst_y%0d", i), ch_y[i], '0);
        @(negedge clk);
        ch_rst = 1'b0;
        step(NCH * LAT);
        check("chain_final_after_rst", ch_y[NCH-1], Y_TC);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
